// File: rtl/issuer_pkg.sv
// rtl/issuer_pkg.sv - shared types and constants for the instruction issuer
// Contents: issuer FSM state enum, 25-bit instruction field offsets,
// opcode constants and a field-extraction helper.
package issuer_pkg;

  localparam int INSTR_W = 25;

  typedef logic [INSTR_W-1:0] instr_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    ACK,
    EXEC,
    DONE,
    ERR
  } state_t;

  // Instruction word layout: [24:22] opcode, [21:19] Rx, [18:16] Ry, [15:0] imm
  localparam int OPC_MSB = 24;
  localparam int OPC_LSB = 22;
  localparam int RX_MSB  = 21;
  localparam int RX_LSB  = 19;
  localparam int RY_MSB  = 18;
  localparam int RY_LSB  = 16;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_MOV  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;

  function automatic logic [2:0] instr_opcode(input instr_t w);
    return w[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/instr_issuer_if.sv
// rtl/instr_issuer_if.sv - issuer-to-processor instruction handshake bundle
// Signals: func (25-bit instruction), new_func (one-cycle issue strobe),
// cur_state (processor state code). master = issuer, slave = processor.
interface instr_issuer_if;
  import issuer_pkg::*;

  instr_t     func;
  logic       new_func;
  logic [4:0] cur_state;

  modport master (
    output func,
    output new_func,
    input  cur_state
  );

  modport slave (
    input  func,
    input  new_func,
    output cur_state
  );

endinterface

// File: rtl/issuer_pmem.sv
// rtl/issuer_pmem.sv - DEPTH x 25 program buffer, synchronous write, registered read
// Ports: clk; wr_en/wr_addr/wr_data write port (gated by the caller);
// rd_addr read address, rd_data registered read data (one cycle latency).
module issuer_pmem
  import issuer_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  instr_t        wr_data,
  input  logic [AW-1:0] rd_addr,
  output instr_t        rd_data
);

  instr_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/instr_issuer.sv
// rtl/instr_issuer.sv - issues buffered instructions to the processor one at a time
// Ports: clk, resetn (sync, active-low); wr_en/wr_addr/wr_data program load;
// start/len run request; bus (master: func, new_func out, cur_state in);
// busy, done (pulse), error (sticky timeout), pc (current instruction index).
module instr_issuer
  import issuer_pkg::*;
#(
  parameter int         DEPTH     = 32,
  parameter int         AW        = 5,
  parameter logic [4:0] WAIT_CODE = 5'b00000,
  parameter int         TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  instr_t               wr_data,
  input  logic                 start,
  input  logic [AW:0]          len,
  instr_issuer_if.master       bus,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [AW-1:0]        pc
);

  localparam int            CW      = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LEN_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PC_ONE  = AW'(1);
  localparam logic [CW-1:0] TO_ONE  = CW'(1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] TO_MAX  = CW'(TIMEOUT);

  state_t        state;
  state_t        next_state;
  logic [AW:0]   len_q;
  logic [CW-1:0] tmo_cnt;
  instr_t        func_q;
  instr_t        rd_data;
  logic          is_wait;
  logic          is_last;
  logic          tmo_hit;

  // pc always addresses the buffer; the read registered at the end of FETCH
  // is the word presented during ISSUE.
  issuer_pmem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_pmem (
    .clk     (clk),
    .wr_en   (wr_en && !busy),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (pc),
    .rd_data (rd_data)
  );

  assign is_wait = (bus.cur_state == WAIT_CODE);
  // Widened compare so len_q == DEPTH ends at DEPTH-1 rather than wrapping pc.
  assign is_last = ({1'b0, pc} == (len_q - LEN_ONE));
  // tmo_cnt counts cycles already spent in the state; this is the TIMEOUT-th.
  assign tmo_hit = (tmo_cnt >= TO_LAST);

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          next_state = (len == '0) ? DONE : FETCH;
        end
      end
      FETCH: next_state = ISSUE;
      ISSUE: next_state = ACK;
      ACK: begin
        if (!is_wait) begin
          next_state = EXEC;
        end else if (tmo_hit) begin
          next_state = ERR;
        end
      end
      EXEC: begin
        if (is_wait) begin
          next_state = is_last ? DONE : FETCH;
        end else if (tmo_hit) begin
          next_state = ERR;
        end
      end
      DONE:    next_state = IDLE;
      ERR:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      pc      <= '0;
      len_q   <= '0;
      tmo_cnt <= '0;
      func_q  <= '0;
      error   <= 1'b0;
    end else begin
      state <= next_state;

      if (next_state != state) begin
        tmo_cnt <= '0;
      end else if (tmo_cnt != TO_MAX) begin
        tmo_cnt <= tmo_cnt + TO_ONE;
      end

      if (state == IDLE && start && len != '0) begin
        pc    <= '0;
        len_q <= (len > DEPTH_L) ? DEPTH_L : len;
        error <= 1'b0;
      end

      if (state == EXEC && is_wait && !is_last) begin
        pc <= pc + PC_ONE;
      end

      // Capture the issued word so it stays on func through ACK/EXEC and after.
      if (state == ISSUE) begin
        func_q <= rd_data;
      end

      if (next_state == ERR) begin
        func_q <= '0;
        error  <= 1'b1;
      end
    end
  end

  assign bus.func     = (state == ISSUE) ? rd_data : func_q;
  assign bus.new_func = (state == ISSUE);
  assign busy         = !(state == IDLE || state == DONE);
  assign done         = (state == DONE);

endmodule

// File: tb/tb_instr_issuer.sv
// tb/tb_instr_issuer.sv - directed self-checking bench for instr_issuer
module tb_instr_issuer;
  import issuer_pkg::*;

  localparam logic [4:0] WAITC = 5'b00000;
  localparam logic [4:0] RUNC  = 5'b00011;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [24:0] wr_data = '0;
  logic        start = 1'b0;
  logic [5:0]  len = '0;
  logic        busy;
  logic        done;
  logic        error;
  logic [4:0]  pc;

  int checks = 0;
  int errors = 0;
  int nf_count = 0;
  int base = 0;

  logic [24:0] prog [4];

  instr_issuer_if bus_if ();

  instr_issuer #(
    .DEPTH     (32),
    .AW        (5),
    .WAIT_CODE (WAITC),
    .TIMEOUT   (64)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .start   (start),
    .len     (len),
    .bus     (bus_if),
    .busy    (busy),
    .done    (done),
    .error   (error),
    .pc      (pc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus_if.new_func === 1'b1) nf_count <= nf_count + 1;
  end

  function automatic logic [24:0] pat(input int i);
    return 25'h0A00000 + 25'(i);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_word(input int addr, input logic [24:0] data);
    wr_en = 1'b1;
    wr_addr = 5'(addr);
    wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic start_run(input int n);
    start = 1'b1;
    len = 6'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits (bounded) for the issue cycle, checks the word, plays a processor
  // that is non-wait for 'nonwait' sampled cycles, then returns to wait.
  // Leaves the caller in the cycle after the processor returned to wait.
  task automatic exec_one(input logic [24:0] word, input int nonwait, input string tag);
    int k;
    k = 0;
    while (bus_if.new_func !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_issue"}, 32'(bus_if.new_func), 32'd1);
    chk({tag, "_func"}, 32'(bus_if.func), 32'(word));
    bus_if.cur_state = RUNC;
    for (int i = 0; i < nonwait; i++) begin
      @(negedge clk);
      chk({tag, "_stable"}, 32'(bus_if.func), 32'(word));
      chk({tag, "_nf_low"}, 32'(bus_if.new_func), 32'd0);
    end
    bus_if.cur_state = WAITC;
    @(negedge clk);
  endtask

  initial begin
    prog[0] = 25'h0000001;
    prog[1] = 25'h0480000;
    prog[2] = 25'h0810000;
    prog[3] = 25'h0100002;
    bus_if.cur_state = WAITC;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_func", 32'(bus_if.func), 32'd0);
    chk("rst_new_func", 32'(bus_if.new_func), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // Program run; word 0 is written in the same cycle as start
    write_word(1, prog[1]);
    write_word(2, prog[2]);
    write_word(3, prog[3]);
    base = nf_count;
    wr_en = 1'b1;
    wr_addr = 5'd0;
    wr_data = prog[0];
    start_run(4);
    wr_en = 1'b0;
    chk("lat_fetch_busy", 32'(busy), 32'd1);
    chk("lat_fetch_nf", 32'(bus_if.new_func), 32'd0);
    @(negedge clk);
    chk("lat_issue_nf", 32'(bus_if.new_func), 32'd1);
    exec_one(prog[0], 3, "p0");
    exec_one(prog[1], 3, "p1");
    exec_one(prog[2], 3, "p2");
    exec_one(prog[3], 3, "p3");
    chk("run_done", 32'(done), 32'd1);
    chk("run_busy", 32'(busy), 32'd0);
    chk("run_count", 32'(nf_count - base), 32'd4);
    chk("run_pc", 32'(pc), 32'd3);
    chk("run_func_last", 32'(bus_if.func), 32'(prog[3]));
    @(negedge clk);
    chk("run_done_pulse", 32'(done), 32'd0);

    // Zero length
    base = nf_count;
    start_run(0);
    chk("zl_done", 32'(done), 32'd1);
    chk("zl_busy", 32'(busy), 32'd0);
    chk("zl_nf", 32'(bus_if.new_func), 32'd0);
    @(negedge clk);
    chk("zl_done_off", 32'(done), 32'd0);
    chk("zl_busy_off", 32'(busy), 32'd0);
    chk("zl_count", 32'(nf_count - base), 32'd0);

    // Timeout in ACK: processor never leaves wait
    start_run(1);
    @(negedge clk);
    chk("to_issue", 32'(bus_if.new_func), 32'd1);
    repeat (64) @(negedge clk);
    chk("to_last_ack_err", 32'(error), 32'd0);
    chk("to_last_ack_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("to_err_error", 32'(error), 32'd1);
    chk("to_err_func", 32'(bus_if.func), 32'd0);
    chk("to_err_nf", 32'(bus_if.new_func), 32'd0);
    @(negedge clk);
    chk("to_idle_busy", 32'(busy), 32'd0);
    chk("to_idle_error", 32'(error), 32'd1);
    start_run(1);
    chk("to_clear_error", 32'(error), 32'd0);
    exec_one(prog[0], 2, "to_clr");
    chk("to_clr_done", 32'(done), 32'd1);
    @(negedge clk);

    // Clamp: len 33 runs 32 instructions and stops at pc 31
    for (int i = 0; i < 32; i++) write_word(i, pat(i));
    base = nf_count;
    start_run(33);
    for (int i = 0; i < 32; i++) exec_one(pat(i), 2, "cl");
    chk("cl_done", 32'(done), 32'd1);
    chk("cl_pc", 32'(pc), 32'd31);
    chk("cl_count", 32'(nf_count - base), 32'd32);
    chk("cl_func", 32'(bus_if.func), 32'(pat(31)));
    @(negedge clk);

    // Write and start while busy are ignored
    base = nf_count;
    start_run(2);
    wr_en = 1'b1;
    wr_addr = 5'd1;
    wr_data = 25'h1FFFFFF;
    start = 1'b1;
    len = 6'd0;
    @(negedge clk);
    wr_en = 1'b0;
    start = 1'b0;
    exec_one(pat(0), 3, "ig0");
    exec_one(pat(1), 3, "ig1");
    chk("ig_done", 32'(done), 32'd1);
    chk("ig_count", 32'(nf_count - base), 32'd2);
    @(negedge clk);
    start_run(2);
    exec_one(pat(0), 2, "rd0");
    exec_one(pat(1), 2, "rd1");
    chk("rd_done", 32'(done), 32'd1);
    @(negedge clk);

    // Reset during EXEC
    base = nf_count;
    start_run(2);
    @(negedge clk);
    bus_if.cur_state = RUNC;
    @(negedge clk);
    @(negedge clk);
    chk("rm_exec_busy", 32'(busy), 32'd1);
    resetn = 1'b0;
    @(negedge clk);
    chk("rm_func", 32'(bus_if.func), 32'd0);
    chk("rm_nf", 32'(bus_if.new_func), 32'd0);
    chk("rm_busy", 32'(busy), 32'd0);
    chk("rm_done", 32'(done), 32'd0);
    chk("rm_error", 32'(error), 32'd0);
    chk("rm_pc", 32'(pc), 32'd0);
    bus_if.cur_state = WAITC;
    @(negedge clk);
    resetn = 1'b1;
    repeat (10) @(negedge clk);
    chk("rm_count", 32'(nf_count - base), 32'd1);
    chk("rm_idle_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
